// File: rtl/decode_read_stage_if.sv
// rtl/decode_read_stage_if.sv - fetch/writeback/execute bundle for decode_read_stage.
// master: the surrounding pipeline; slave: the decode/register-read stage.
interface decode_read_stage_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            wb_we;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_rs1_data;
  logic [XLEN-1:0] out_rs2_data;
  logic [XLEN-1:0] out_imm;
  logic [3:0]      out_alu_op;
  logic [2:0]      out_funct3;
  logic [AW-1:0]   out_rd;
  logic [AW-1:0]   out_rs1;
  logic [AW-1:0]   out_rs2;
  logic            out_a_sel;
  logic            out_b_sel;
  logic            out_reg_we;
  logic            out_mem_we;
  logic            out_mem_rr;
  logic            out_csr_write;
  logic            out_is_jump;
  logic            out_jump_cond;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_instr, wb_we, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, out_rs1_data, out_rs2_data, out_imm, out_alu_op,
           out_funct3, out_rd, out_rs1, out_rs2, out_a_sel, out_b_sel, out_reg_we,
           out_mem_we, out_mem_rr, out_csr_write, out_is_jump, out_jump_cond, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, wb_we, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, out_rs1_data, out_rs2_data, out_imm, out_alu_op,
           out_funct3, out_rd, out_rs1, out_rs2, out_a_sel, out_b_sel, out_reg_we,
           out_mem_we, out_mem_rr, out_csr_write, out_is_jump, out_jump_cond, out_illegal
  );
endinterface

// File: rtl/decode_read_stage.sv
// rtl/decode_read_stage.sv - RV decode + register read stage with load-use scoreboard.
// Optional DECODE_BYPASS_EN forwards same-cycle writeback data into operands and the hazard check.
module decode_read_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic                clk,
  input logic                rst_n,
  decode_read_stage_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic [2:0]      funct3;
    logic [AW-1:0]   rd;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            a_sel;
    logic            b_sel;
    logic            reg_we;
    logic            mem_we;
    logic            mem_rr;
    logic            csr_write;
    logic            is_jump;
    logic            jump_cond;
    logic            illegal;
  } bundle_t;

  logic [XLEN-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_pending;
  logic [NREGS-1:0] w_pending_nxt;
  logic            r_out_valid;
  bundle_t         r_out;
  bundle_t         w_dec;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic            w_f7b5;
  logic [AW-1:0]   w_rd;
  logic [AW-1:0]   w_rs1_raw;
  logic [AW-1:0]   w_rs1;
  logic [AW-1:0]   w_rs2;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_rs1_used;
  logic            w_rs2_used;
  logic            w_illegal;
  logic            w_reg_we;
  logic            w_mem_we;
  logic            w_mem_rr;
  logic            w_csr_write;
  logic            w_is_jump;
  logic            w_jump_cond;
  logic            w_a_sel;
  logic            w_b_sel;
  logic [3:0]      w_alu_op;
  logic [XLEN-1:0] w_rs1_rf;
  logic [XLEN-1:0] w_rs2_rf;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic            w_byp1;
  logic            w_byp2;
  logic            w_hazard;
  logic            w_in_ready;
  logic            w_fire_in;
  logic            w_load_set;

  assign w_opcode  = bus.in_instr[6:0];
  assign w_funct3  = bus.in_instr[14:12];
  assign w_f7b5    = bus.in_instr[30];
  assign w_rd      = AW'(bus.in_instr[11:7]);
  assign w_rs1_raw = AW'(bus.in_instr[19:15]);
  assign w_rs2     = AW'(bus.in_instr[24:20]);

  always_comb begin
    w_imm32     = 32'd0;
    w_rs1_used  = 1'b1;
    w_rs2_used  = 1'b0;
    w_illegal   = 1'b0;
    w_reg_we    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_rr    = 1'b0;
    w_csr_write = 1'b0;
    w_is_jump   = 1'b0;
    w_jump_cond = 1'b0;
    w_a_sel     = 1'b1;
    w_b_sel     = 1'b1;
    w_alu_op    = 4'b0000;
    case (w_opcode)
      OPC_LUI: begin
        w_imm32    = {bus.in_instr[31:12], 12'd0};
        w_rs1_used = 1'b0;
        w_reg_we   = 1'b1;
      end
      OPC_AUIPC: begin
        w_imm32    = {bus.in_instr[31:12], 12'd0};
        w_rs1_used = 1'b0;
        w_reg_we   = 1'b1;
        w_a_sel    = 1'b0;
      end
      OPC_JAL: begin
        w_imm32    = {{12{bus.in_instr[31]}}, bus.in_instr[19:12], bus.in_instr[20],
                      bus.in_instr[30:21], 1'b0};
        w_rs1_used = 1'b0;
        w_reg_we   = 1'b1;
        w_is_jump  = 1'b1;
        w_a_sel    = 1'b0;
      end
      OPC_JALR: begin
        w_imm32   = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
        w_reg_we  = 1'b1;
        w_is_jump = 1'b1;
      end
      OPC_BRANCH: begin
        // Operands carry the compare; a/b select the target computation PC + imm.
        w_imm32     = {{20{bus.in_instr[31]}}, bus.in_instr[7], bus.in_instr[30:25],
                       bus.in_instr[11:8], 1'b0};
        w_rs2_used  = 1'b1;
        w_is_jump   = 1'b1;
        w_jump_cond = 1'b1;
        w_a_sel     = 1'b0;
      end
      OPC_LOAD: begin
        w_imm32  = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
        w_reg_we = 1'b1;
        w_mem_rr = 1'b1;
      end
      OPC_STORE: begin
        w_imm32    = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
        w_rs2_used = 1'b1;
        w_mem_we   = 1'b1;
      end
      OPC_OP_IMM: begin
        // funct7[5] only selects SRAI; for other I-type ops that bit is immediate.
        w_imm32  = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
        w_reg_we = 1'b1;
        w_alu_op = {(w_funct3 == 3'b101) & w_f7b5, w_funct3};
      end
      OPC_OP: begin
        w_rs2_used = 1'b1;
        w_reg_we   = 1'b1;
        w_b_sel    = 1'b0;
        w_alu_op   = {w_f7b5, w_funct3};
      end
      OPC_FENCE: begin
        w_imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
      end
      OPC_SYSTEM: begin
        w_imm32     = {20'd0, bus.in_instr[31:20]};
        w_reg_we    = (w_funct3 != 3'b000);
        w_csr_write = (w_funct3 != 3'b000);
      end
      default: w_illegal = 1'b1;
    endcase
  end

  generate
    if (XLEN > 32) begin : g_sext
      assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_trunc
      assign w_imm = w_imm32[XLEN-1:0];
    end
  endgenerate

  // Unused rs1 reads index x0 so LUI sees a zero first operand.
  assign w_rs1    = w_rs1_used ? w_rs1_raw : '0;
  assign w_rs1_rf = (w_rs1 == '0) ? '0 : r_regs[w_rs1];
  assign w_rs2_rf = (w_rs2 == '0) ? '0 : r_regs[w_rs2];

`ifdef DECODE_BYPASS_EN
  assign w_byp1     = bus.wb_we && (bus.wb_addr == w_rs1) && (w_rs1 != '0);
  assign w_byp2     = bus.wb_we && (bus.wb_addr == w_rs2) && (w_rs2 != '0);
  assign w_rs1_data = w_byp1 ? bus.wb_data : w_rs1_rf;
  assign w_rs2_data = w_byp2 ? bus.wb_data : w_rs2_rf;
`else
  assign w_byp1     = 1'b0;
  assign w_byp2     = 1'b0;
  assign w_rs1_data = w_rs1_rf;
  assign w_rs2_data = w_rs2_rf;
`endif

  assign w_hazard = (w_rs1_used && (w_rs1 != '0) && r_pending[w_rs1] && !w_byp1) ||
                    (w_rs2_used && (w_rs2 != '0) && r_pending[w_rs2] && !w_byp2);

  assign w_in_ready = !bus.flush && !w_hazard && (!r_out_valid || bus.out_ready);
  assign w_fire_in  = bus.in_valid && w_in_ready;
  assign w_load_set = w_fire_in && (w_opcode == OPC_LOAD) && (w_rd != '0);

  always_comb begin
    w_dec           = '0;
    w_dec.rs1_data  = w_rs1_data;
    w_dec.rs2_data  = w_rs2_data;
    w_dec.imm       = w_imm;
    w_dec.alu_op    = w_alu_op;
    w_dec.funct3    = w_funct3;
    w_dec.rd        = w_rd;
    w_dec.rs1       = w_rs1;
    w_dec.rs2       = w_rs2;
    w_dec.a_sel     = w_a_sel;
    w_dec.b_sel     = w_b_sel;
    w_dec.reg_we    = w_reg_we;
    w_dec.mem_we    = w_mem_we;
    w_dec.mem_rr    = w_mem_rr;
    w_dec.csr_write = w_csr_write;
    w_dec.is_jump   = w_is_jump;
    w_dec.jump_cond = w_jump_cond;
    w_dec.illegal   = w_illegal;
  end

  // Set after clear so a load issuing to the register being written back stays pending.
  always_comb begin
    w_pending_nxt = r_pending;
    for (int i = 0; i < NREGS; i++) begin
      if (bus.wb_we && (bus.wb_addr == AW'(i))) w_pending_nxt[i] = 1'b0;
      if (w_load_set && (w_rd == AW'(i)))       w_pending_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending   <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (bus.flush) begin
        r_out_valid <= 1'b0;
      end else if (!r_out_valid || bus.out_ready) begin
        r_out_valid <= w_fire_in;
        if (w_fire_in) r_out <= w_dec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.wb_we && (bus.wb_addr != '0)) r_regs[bus.wb_addr] <= bus.wb_data;
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_rs1_data  = r_out.rs1_data;
  assign bus.out_rs2_data  = r_out.rs2_data;
  assign bus.out_imm       = r_out.imm;
  assign bus.out_alu_op    = r_out.alu_op;
  assign bus.out_funct3    = r_out.funct3;
  assign bus.out_rd        = r_out.rd;
  assign bus.out_rs1       = r_out.rs1;
  assign bus.out_rs2       = r_out.rs2;
  assign bus.out_a_sel     = r_out.a_sel;
  assign bus.out_b_sel     = r_out.b_sel;
  assign bus.out_reg_we    = r_out.reg_we;
  assign bus.out_mem_we    = r_out.mem_we;
  assign bus.out_mem_rr    = r_out.mem_rr;
  assign bus.out_csr_write = r_out.csr_write;
  assign bus.out_is_jump   = r_out.is_jump;
  assign bus.out_jump_cond = r_out.jump_cond;
  assign bus.out_illegal   = r_out.illegal;
endmodule

// File: tb/tb_decode_read_stage.sv
// tb/tb_decode_read_stage.sv - directed self-checking bench for decode_read_stage.
module tb_decode_read_stage;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  decode_read_stage_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

  decode_read_stage #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] t_ins [6];
  logic [31:0] t_imm [6];
  logic [3:0]  t_alu [6];
  logic        t_j   [6];
  logic        t_jc  [6];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    t_ins[0] = {12'hFFF, 5'd0, 3'b000, 5'd1, 7'b0010011};                    // ADDI x1,x0,-1
    t_imm[0] = 32'hFFFF_FFFF; t_alu[0] = 4'b0000; t_j[0] = 0; t_jc[0] = 0;
    t_ins[1] = {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};          // SUB x3,x1,x2
    t_imm[1] = 32'h0;         t_alu[1] = 4'b1000; t_j[1] = 0; t_jc[1] = 0;
    t_ins[2] = {7'b0100000, 5'd3, 5'd1, 3'b101, 5'd1, 7'b0010011};          // SRAI x1,x1,3
    t_imm[2] = 32'h403;       t_alu[2] = 4'b1101; t_j[2] = 0; t_jc[2] = 0;
    t_ins[3] = {1'b0, 6'd0, 5'd2, 5'd1, 3'b000, 4'b1000, 1'b0, 7'b1100011}; // BEQ x1,x2,+16
    t_imm[3] = 32'd16;        t_alu[3] = 4'b0000; t_j[3] = 1; t_jc[3] = 1;
    t_ins[4] = {1'b1, 10'b1111111110, 1'b1, 8'hFF, 5'd1, 7'b1101111};       // JAL x1,-4
    t_imm[4] = 32'hFFFF_FFFC; t_alu[4] = 4'b0000; t_j[4] = 1; t_jc[4] = 0;
    t_ins[5] = {20'h12345, 5'd5, 7'b0110111};                                // LUI x5,0x12345
    t_imm[5] = 32'h1234_5000; t_alu[5] = 4'b0000; t_j[5] = 0; t_jc[5] = 0;

    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = NOP;
    bus.wb_we     = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_reg_we", bus.out_reg_we, 0);
    check("rst_rd", bus.out_rd, 0);
    check("rst_imm", bus.out_imm, 0);
    rst_n = 1'b1;

    // ADDI x1,x0,5
    bus.in_valid = 1'b1;
    bus.in_instr = {12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011};
    bus.out_ready = 1'b1;
    #1 check("addi_in_ready", bus.in_ready, 1);
    tick();
    check("addi_valid", bus.out_valid, 1);
    check("addi_rd", bus.out_rd, 1);
    check("addi_imm", bus.out_imm, 5);
    check("addi_reg_we", bus.out_reg_we, 1);
    check("addi_b_sel", bus.out_b_sel, 1);
    check("addi_a_sel", bus.out_a_sel, 1);

    // LW x2,0(x1) then ADD x3,x2,x2 stalls on the pending load
    bus.in_instr = {12'd0, 5'd1, 3'b010, 5'd2, 7'b0000011};
    tick();
    check("lw_mem_rr", bus.out_mem_rr, 1);
    bus.in_instr = {7'd0, 5'd2, 5'd2, 3'b000, 5'd3, 7'b0110011};
    #1 check("hazard_in_ready", bus.in_ready, 0);
    tick();
    check("hazard_bubble", bus.out_valid, 0);
    bus.wb_we   = 1'b1;
    bus.wb_addr = 5'd2;
    bus.wb_data = 32'h55;
`ifdef DECODE_BYPASS_EN
    #1 check("wb_in_ready", bus.in_ready, 1);
    tick();
    bus.wb_we = 1'b0;
`else
    #1 check("wb_in_ready", bus.in_ready, 0);
    tick();
    bus.wb_we = 1'b0;
    check("wb_still_bubble", bus.out_valid, 0);
    #1 check("post_wb_in_ready", bus.in_ready, 1);
    tick();
`endif
    bus.in_valid = 1'b0;
    check("add_valid", bus.out_valid, 1);
    check("add_rs1_data", bus.out_rs1_data, 32'h55);
    check("add_rs2_data", bus.out_rs2_data, 32'h55);
    check("add_rd", bus.out_rd, 3);
    check("add_b_sel", bus.out_b_sel, 0);

    // SW x4,8(x5) held by out_ready=0
    bus.in_valid = 1'b1;
    bus.in_instr = {7'd0, 5'd4, 5'd5, 3'b010, 5'd8, 7'b0100011};
    tick();
    bus.out_ready = 1'b0;
    bus.in_instr  = NOP;
    for (int i = 0; i < 3; i++) begin
      #1 check("hold_in_ready", bus.in_ready, 0);
      tick();
      check("hold_valid", bus.out_valid, 1);
      check("hold_mem_we", bus.out_mem_we, 1);
      check("hold_imm", bus.out_imm, 8);
    end
    check("sw_rs1", bus.out_rs1, 5);
    check("sw_rs2", bus.out_rs2, 4);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("sw_released", bus.out_valid, 0);

    // Flush with a pending load on x8
    bus.in_valid = 1'b1;
    bus.in_instr = {12'd0, 5'd0, 3'b010, 5'd8, 7'b0000011};
    tick();
    check("lw8_valid", bus.out_valid, 1);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b0;
    bus.in_instr  = {7'd0, 5'd1, 5'd1, 3'b000, 5'd9, 7'b0110011};
    #1 check("flush_in_ready", bus.in_ready, 0);
    tick();
    check("flush_valid", bus.out_valid, 0);
    bus.flush    = 1'b0;
    bus.in_instr = {7'd0, 5'd0, 5'd8, 3'b000, 5'd10, 7'b0110011};
    #1 check("flush_pending_kept", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    bus.wb_we     = 1'b1;
    bus.wb_addr   = 5'd8;
    bus.wb_data   = 32'h77;
    tick();

    // LW x0 never stalls; writes to x0 are dropped
    bus.in_valid = 1'b1;
    bus.in_instr = {12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011};
    bus.wb_addr  = 5'd0;
    bus.wb_data  = 32'hDEAD;
    tick();
    bus.wb_we    = 1'b0;
    bus.in_instr = {7'd0, 5'd0, 5'd0, 3'b000, 5'd6, 7'b0110011};
    #1 check("x0_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    check("x0_valid", bus.out_valid, 1);
    check("x0_rd", bus.out_rd, 6);
    check("x0_rs1_data", bus.out_rs1_data, 0);
    check("x0_rs2_data", bus.out_rs2_data, 0);

    // Immediate and ALU-op decode table
    for (int k = 0; k < 6; k++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = t_ins[k];
      tick();
      bus.in_valid = 1'b0;
      check($sformatf("tbl%0d_imm", k), bus.out_imm, t_imm[k]);
      check($sformatf("tbl%0d_alu", k), bus.out_alu_op, t_alu[k]);
      check($sformatf("tbl%0d_jump", k), bus.out_is_jump, t_j[k]);
      check($sformatf("tbl%0d_cond", k), bus.out_jump_cond, t_jc[k]);
    end

    // Illegal opcode
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h0000_007F;
    tick();
    bus.in_valid = 1'b0;
    check("ill_valid", bus.out_valid, 1);
    check("ill_flag", bus.out_illegal, 1);
    check("ill_reg_we", bus.out_reg_we, 0);
    check("ill_mem_we", bus.out_mem_we, 0);
    check("ill_mem_rr", bus.out_mem_rr, 0);
    check("ill_csr", bus.out_csr_write, 0);
    check("ill_jump", bus.out_is_jump, 0);

    // Reset in the middle of a load-use stall
    bus.in_valid = 1'b1;
    bus.in_instr = {12'd0, 5'd0, 3'b010, 5'd3, 7'b0000011};
    tick();
    bus.out_ready = 1'b0;
    bus.in_instr  = {7'd0, 5'd0, 5'd3, 3'b000, 5'd4, 7'b0110011};
    #1 check("stall_in_ready", bus.in_ready, 0);
    #2 rst_n = 1'b0;
    #1 check("async_rst_valid", bus.out_valid, 0);
    tick();
    rst_n = 1'b1;
    #1 check("rst_pending_clear", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    check("post_rst_valid", bus.out_valid, 1);
    check("post_rst_rd", bus.out_rd, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
